// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared defaults and small helpers for the FIFO read-side controller and its
// two-entry output skid buffer.
package fifo_rd_ctrl_pkg;

    localparam int ADDR_DEF   = 3;
    localparam int WORDS_DEF  = 8;
    localparam int W_SIZE_DEF = 8;

    // Encoded as {push, pop} so the skid buffer can case on it directly.
    typedef enum logic [1:0] {
        SKID_HOLD  = 2'b00,
        SKID_POP   = 2'b01,
        SKID_PUSH  = 2'b10,
        SKID_SHIFT = 2'b11
    } skid_op_e;

    function automatic skid_op_e skid_op(input logic push, input logic pop);
        return skid_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle: consumer valid/ready stream, flush, level, and the
// storage array read port.
interface fifo_rd_ctrl_if
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR   = ADDR_DEF,
    parameter int W_SIZE = W_SIZE_DEF
);
    logic              rd_flush;
    logic              rd_ready;
    logic              rd_valid;
    logic [W_SIZE-1:0] rd_data;
    logic [ADDR:0]     rd_level;
    logic [ADDR-1:0]   mem_raddr;
    logic [W_SIZE-1:0] mem_rdata;

    modport master (
        input  rd_flush, rd_ready, mem_rdata,
        output rd_valid, rd_data, rd_level, mem_raddr
    );

    modport slave (
        output rd_flush, rd_ready, mem_rdata,
        input  rd_valid, rd_data, rd_level, mem_raddr
    );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry output skid buffer: head drives the stream, tail catches the word
// that was already in flight when the consumer stalled.
module fifo_rd_skid
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int W_SIZE = W_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [W_SIZE-1:0] push_data,
    input  logic              pop,
    input  logic              clr,
    output logic              valid,
    output logic [W_SIZE-1:0] data,
    output logic [1:0]        cnt
);

    logic [W_SIZE-1:0] head_p2;
    logic [W_SIZE-1:0] tail_p2;
    logic [1:0]        cnt_p2;
    logic              pop_ok;
    skid_op_e          op;

    assign pop_ok = pop & (cnt_p2 != 2'd0);
    assign op     = skid_op(push, pop_ok);

    // Stage 2: buffered words, head first
    always_ff @(posedge clk) begin
        if (rst) begin
            head_p2 <= '0;
            tail_p2 <= '0;
            cnt_p2  <= 2'd0;
        end else if (clr) begin
            cnt_p2 <= 2'd0;
        end else begin
            unique case (op)
                SKID_PUSH: begin
                    if (cnt_p2 == 2'd0)
                        head_p2 <= push_data;
                    else
                        tail_p2 <= push_data;
                    if (cnt_p2 != 2'd2)
                        cnt_p2 <= cnt_p2 + 2'd1;
                end
                SKID_POP: begin
                    head_p2 <= tail_p2;
                    cnt_p2  <= cnt_p2 - 2'd1;
                end
                SKID_SHIFT: begin
                    if (cnt_p2 == 2'd1) begin
                        head_p2 <= push_data;
                    end else begin
                        head_p2 <= tail_p2;
                        tail_p2 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (cnt_p2 != 2'd0);
    assign data  = head_p2;
    assign cnt   = cnt_p2;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: owns the binary read pointer, absorbs the array's
// registered read latency and streams words to the MAC consumer.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR   = ADDR_DEF,
    parameter int WORDS  = WORDS_DEF,
    parameter int W_SIZE = W_SIZE_DEF
) (
    input  logic            fifo_rclk,
    input  logic            fifo_rrst,
    input  logic [ADDR:0]   wptr_bin,
    output logic [ADDR:0]   rptr_bin,
    fifo_rd_ctrl_if.master  rd
);

    localparam logic [ADDR:0] ADDR_MASK = (ADDR + 1)'(WORDS - 1);

    logic              ptr_empty;
    logic              pop;
    logic              fetch;
    logic              pending_p1;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ;
    logic              buf_valid;
    logic [W_SIZE-1:0] buf_data;

    assign ptr_empty = (wptr_bin == rptr_bin);
    assign pop       = buf_valid & rd.rd_ready;
    assign occ       = {1'b0, buf_cnt} + {2'b00, pending_p1};

    // occ never underflows here: pop implies at least one buffered word.
    assign fetch = ~ptr_empty & ~rd.rd_flush & ((occ - {2'b00, pop}) < 3'd2);

    // Stage 1: address issued, array read in flight
    always_ff @(posedge fifo_rclk) begin
        if (fifo_rrst) begin
            rptr_bin   <= '0;
            pending_p1 <= 1'b0;
        end else if (rd.rd_flush) begin
            rptr_bin   <= wptr_bin;
            pending_p1 <= 1'b0;
        end else begin
            if (fetch)
                rptr_bin <= rptr_bin + 1'b1;
            pending_p1 <= fetch;
        end
    end

    fifo_rd_skid #(
        .W_SIZE (W_SIZE)
    ) u_skid (
        .clk       (fifo_rclk),
        .rst       (fifo_rrst),
        .push      (pending_p1),
        .push_data (rd.mem_rdata),
        .pop       (pop),
        .clr       (rd.rd_flush),
        .valid     (buf_valid),
        .data      (buf_data),
        .cnt       (buf_cnt)
    );

    assign rd.mem_raddr = ADDR'(rptr_bin & ADDR_MASK);
    assign rd.rd_valid  = buf_valid;
    assign rd.rd_data   = buf_data;
    assign rd.rd_level  = wptr_bin - rptr_bin;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed plus randomized bench for fifo_rd_ctrl; the random phase checks the
// stream against an in-order queue of written words.
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wptr;
    logic [3:0] rptr;
    logic [7:0] mem [8];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] q [$];

    fifo_rd_ctrl_if #(.ADDR(3), .W_SIZE(8)) rif ();

    fifo_rd_ctrl #(.ADDR(3), .WORDS(8), .W_SIZE(8)) dut (
        .fifo_rclk (clk),
        .fifo_rrst (rst),
        .wptr_bin  (wptr),
        .rptr_bin  (rptr),
        .rd        (rif)
    );

    always #5 clk = ~clk;

    // Registered array read port
    always @(posedge clk) rif.mem_rdata <= mem[rif.mem_raddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] w);
        rst = 1'b1;
        wptr = w;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic       hold;
        logic [7:0] hold_data;
        logic [7:0] d;
        logic [3:0] diff;
        logic       rdy;
        logic       fl;

        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        rst = 1'b1;
        wptr = 4'd5;
        rif.rd_ready = 1'b0;
        rif.rd_flush = 1'b0;

        // Reset state, then first fetch right after release
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_rptr", rptr, 0);
            chk("rst_raddr", rif.mem_raddr, 0);
            chk("rst_valid", rif.rd_valid, 0);
            chk("rst_data", rif.rd_data, 0);
        end
        rst = 1'b0;
        tick();
        chk("first_fetch_rptr", rptr, 1);

        // Single word latency
        do_reset(4'd0);
        mem[0] = 8'hA5;
        rif.rd_ready = 1'b1;
        wptr = 4'd1;
        tick();
        chk("single_e0_valid", rif.rd_valid, 0);
        tick();
        chk("single_e1_valid", rif.rd_valid, 1);
        chk("single_e1_data", rif.rd_data, 8'hA5);
        chk("single_rptr", rptr, 1);
        chk("single_level", rif.rd_level, 0);
        tick();
        chk("single_e2_valid", rif.rd_valid, 0);

        // Full-rate stream of eight words
        do_reset(4'd0);
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        wptr = 4'd8;
        rif.rd_ready = 1'b1;
        tick();
        chk("stream_lat_valid", rif.rd_valid, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stream_valid", rif.rd_valid, 1);
            chk("stream_data", rif.rd_data, 32'h10 + i);
        end
        tick();
        chk("stream_end_valid", rif.rd_valid, 0);
        chk("stream_end_rptr", rptr, 8);

        // Backpressure after three pops
        do_reset(4'd0);
        wptr = 4'd8;
        rif.rd_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_pre_data", rif.rd_data, 32'h10 + i);
        end
        tick();
        chk("bp_head", rif.rd_data, 8'h13);
        chk("bp_rptr", rptr, 5);
        rif.rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", rif.rd_valid, 1);
            chk("bp_hold_data", rif.rd_data, 8'h13);
            chk("bp_hold_rptr", rptr, 5);
        end
        rif.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_resume_valid", rif.rd_valid, 1);
            chk("bp_resume_data", rif.rd_data, 32'h14 + i);
        end
        tick();
        chk("bp_end_valid", rif.rd_valid, 0);
        chk("bp_end_rptr", rptr, 8);

        // Pointer wrap: move read pointer to 14 with a flush
        wptr = 4'd14;
        rif.rd_flush = 1'b1;
        tick();
        rif.rd_flush = 1'b0;
        chk("wrap_setup_rptr", rptr, 14);
        mem[6] = 8'h61; mem[7] = 8'h71; mem[0] = 8'h01; mem[1] = 8'h11;
        wptr = 4'd2;
        #1;
        chk("wrap_raddr0", rif.mem_raddr, 6);
        chk("wrap_level0", rif.rd_level, 4);
        tick();
        chk("wrap_raddr1", rif.mem_raddr, 7);
        chk("wrap_level1", rif.rd_level, 3);
        tick();
        chk("wrap_raddr2", rif.mem_raddr, 0);
        chk("wrap_level2", rif.rd_level, 2);
        chk("wrap_data0", rif.rd_data, 8'h61);
        tick();
        chk("wrap_raddr3", rif.mem_raddr, 1);
        chk("wrap_level3", rif.rd_level, 1);
        chk("wrap_data1", rif.rd_data, 8'h71);
        tick();
        chk("wrap_rptr", rptr, 2);
        chk("wrap_level4", rif.rd_level, 0);
        chk("wrap_data2", rif.rd_data, 8'h01);
        tick();
        chk("wrap_data3", rif.rd_data, 8'h11);
        chk("wrap_valid3", rif.rd_valid, 1);
        tick();
        chk("wrap_end_valid", rif.rd_valid, 0);

        // Full array: rptr 3, wptr 11
        wptr = 4'd3;
        rif.rd_flush = 1'b1;
        tick();
        rif.rd_flush = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom_range(0, 255));
        wptr = 4'd11;
        #1;
        chk("full_level", rif.rd_level, 8);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("full_valid", rif.rd_valid, 1);
            chk("full_data", rif.rd_data, mem[(3 + i) % 8]);
        end
        tick();
        chk("full_end_valid", rif.rd_valid, 0);
        chk("full_end_rptr", rptr, 11);

        // Flush with a buffered word and one read in flight, level 3
        for (int i = 0; i < 8; i++) mem[i] = 8'hE0 + 8'(i);
        rif.rd_ready = 1'b0;
        wptr = 4'd0;
        tick();
        tick();
        chk("flush_pre_valid", rif.rd_valid, 1);
        chk("flush_pre_level", rif.rd_level, 3);
        rif.rd_flush = 1'b1;
        rif.rd_ready = 1'b1;
        tick();
        rif.rd_flush = 1'b0;
        chk("flush_valid", rif.rd_valid, 0);
        chk("flush_rptr", rptr, 0);
        chk("flush_level", rif.rd_level, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("flush_no_stale", rif.rd_valid, 0);
        end
        mem[0] = 8'hC3;
        wptr = 4'd1;
        tick();
        chk("post_flush_lat", rif.rd_valid, 0);
        tick();
        chk("post_flush_valid", rif.rd_valid, 1);
        chk("post_flush_data", rif.rd_data, 8'hC3);
        tick();
        chk("post_flush_end", rif.rd_valid, 0);
        chk("post_flush_rptr", rptr, 1);

        // Randomized traffic against an in-order queue model
        do_reset(4'd0);
        rif.rd_ready = 1'b0;
        rif.rd_flush = 1'b0;
        q.delete();
        hold = 1'b0;
        hold_data = 8'h00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            if (cyc == 200) begin
                rst = 1'b1;
                wptr = 4'd0;
                tick();
                chk("rand_rst_valid", rif.rd_valid, 0);
                chk("rand_rst_data", rif.rd_data, 0);
                rst = 1'b0;
                q.delete();
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                chk("rand_stable_valid", rif.rd_valid, 1);
                chk("rand_stable_data", rif.rd_data, hold_data);
            end
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 31) == 0);
            rif.rd_ready = rdy;
            rif.rd_flush = fl;
            if (rif.rd_valid && rdy && !fl) begin
                if (q.size() == 0) begin
                    chk("rand_pop_expected", 0, 1);
                end else begin
                    chk("rand_pop_data", rif.rd_data, q[0]);
                    void'(q.pop_front());
                end
            end
            hold = rif.rd_valid & ~rdy & ~fl;
            hold_data = rif.rd_data;
            diff = wptr - rptr;
            if (diff < 4'd8 && $urandom_range(0, 1) == 1) begin
                d = 8'($urandom_range(0, 255));
                mem[wptr[2:0]] = d;
                wptr = wptr + 4'd1;
                q.push_back(d);
            end
            if (fl) q.delete();
        end

        // Drain whatever the model still expects
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            tick();
            rif.rd_ready = 1'b1;
            rif.rd_flush = 1'b0;
            if (rif.rd_valid) begin
                chk("drain_data", rif.rd_data, q[0]);
                void'(q.pop_front());
            end
        end
        chk("drain_empty", q.size(), 0);
        rif.rd_ready = 1'b1;
        rif.rd_flush = 1'b0;
        tick();
        tick();
        chk("drain_valid", rif.rd_valid, 0);
        chk("drain_level", rif.rd_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
